// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle add/sub, shift-add multiply and restoring divide
// at one bit per clock, with a start/busy/done handshake and double-width results.
module seq_alu #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] inputA,
   input  logic [WIDTH-1:0] inputB,
   input  logic [2:0]       code,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic             swap,
   output logic             div_zero
);

   // state  | meaning
   // S_IDLE | waiting for start; outputs hold the last completed op
   // S_CALC | op in flight; mul/div iterate until the counter hits 1
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CALC = 1'b1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;

   logic [0:0]       state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             swap_pend_q, swap_pend_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic             swap_q, swap_d;
   logic             div_zero_q, div_zero_d;
   logic             done_q, done_d;

   logic             order_swap;
   logic             last_iter;
   logic [WIDTH:0]   add_sum;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   mul_acc_nx;
   logic [WIDTH-1:0] mul_lo_nx;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic             div_ok;
   logic [WIDTH:0]   div_rem_nx;
   logic [WIDTH-1:0] div_quo_nx;

   // sub and div always operate larger-over-smaller; swap records the exchange
   assign order_swap = ((code == OP_SUB) || (code == OP_DIV)) && (inputA < inputB);
   assign last_iter  = (cnt_q == CNT_W'(1));

   assign add_sum = {1'b0, opa_q} + {1'b0, opb_q};

   // opa_q doubles as multiplier shift register (mul) and dividend/quotient (div)
   assign mul_sum    = acc_q + (opa_q[0] ? {1'b0, opb_q} : '0);
   assign mul_acc_nx = {1'b0, mul_sum[WIDTH:1]};
   assign mul_lo_nx  = {mul_sum[0], opa_q[WIDTH-1:1]};

   assign div_shift  = {acc_q[WIDTH-1:0], opa_q[WIDTH-1]};
   assign div_trial  = div_shift - {1'b0, opb_q};
   assign div_ok     = ~div_trial[WIDTH];
   assign div_rem_nx = div_ok ? div_trial : div_shift;
   assign div_quo_nx = {opa_q[WIDTH-2:0], div_ok};

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      swap_pend_d = swap_pend_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      swap_d      = swap_q;
      div_zero_d  = div_zero_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_CALC;
               op_d        = code;
               opa_d       = order_swap ? inputB : inputA;
               opb_d       = order_swap ? inputA : inputB;
               swap_pend_d = order_swap;
               acc_d       = '0;
               cnt_d       = CNT_W'(WIDTH);
            end
         end
         default: begin
            case (op_q)
               OP_ADD: begin
                  state_d     = S_IDLE;
                  done_d      = 1'b1;
                  result_d    = add_sum[WIDTH-1:0];
                  result_hi_d = {{(WIDTH-1){1'b0}}, add_sum[WIDTH]};
                  swap_d      = 1'b0;
                  div_zero_d  = 1'b0;
               end
               OP_SUB: begin
                  state_d     = S_IDLE;
                  done_d      = 1'b1;
                  result_d    = opa_q - opb_q;
                  result_hi_d = '0;
                  swap_d      = swap_pend_q;
                  div_zero_d  = 1'b0;
               end
               OP_MUL: begin
                  acc_d = mul_acc_nx;
                  opa_d = mul_lo_nx;
                  cnt_d = cnt_q - CNT_W'(1);
                  if (last_iter) begin
                     state_d     = S_IDLE;
                     done_d      = 1'b1;
                     result_d    = mul_lo_nx;
                     result_hi_d = mul_acc_nx[WIDTH-1:0];
                     swap_d      = 1'b0;
                     div_zero_d  = 1'b0;
                  end
               end
               OP_DIV: begin
                  if (opb_q == '0) begin
                     state_d     = S_IDLE;
                     done_d      = 1'b1;
                     result_d    = '1;
                     result_hi_d = opa_q;
                     swap_d      = swap_pend_q;
                     div_zero_d  = 1'b1;
                  end else begin
                     acc_d = div_rem_nx;
                     opa_d = div_quo_nx;
                     cnt_d = cnt_q - CNT_W'(1);
                     if (last_iter) begin
                        state_d     = S_IDLE;
                        done_d      = 1'b1;
                        result_d    = div_quo_nx;
                        result_hi_d = div_rem_nx[WIDTH-1:0];
                        swap_d      = swap_pend_q;
                        div_zero_d  = 1'b0;
                     end
                  end
               end
               default: begin
                  state_d     = S_IDLE;
                  done_d      = 1'b1;
                  result_d    = '0;
                  result_hi_d = '0;
                  swap_d      = 1'b0;
                  div_zero_d  = 1'b0;
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         swap_pend_q <= 1'b0;
         result_q    <= '0;
         result_hi_q <= '0;
         swap_q      <= 1'b0;
         div_zero_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         swap_pend_q <= swap_pend_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         swap_q      <= swap_d;
         div_zero_q  <= div_zero_d;
         done_q      <= done_d;
      end
   end

   assign busy      = (state_q == S_CALC);
   assign done      = done_q;
   assign result    = result_q;
   assign result_hi = result_hi_q;
   assign swap      = swap_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: each op's expected outputs and completion latency
// are computed from the operands and queued, then compared when done pulses.
module tb_seq_alu;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] inputA, inputB;
   logic [2:0]   code;
   logic         busy, done, swap, div_zero;
   logic [W-1:0] result, result_hi;

   seq_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .inputA(inputA), .inputB(inputB),
      .code(code), .busy(busy), .done(done), .result(result), .result_hi(result_hi),
      .swap(swap), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] res;
      logic [W-1:0] hi;
      logic         sw;
      logic         dz;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   logic [W-1:0] o_res, o_hi;
   logic         o_sw, o_dz;
   int           o_lat;

   // Expected-value model; drives the op so edge k is the next rising edge.
   task automatic push_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
      exp_t e;
      logic [W:0]     s;
      logic [2*W-1:0] p;
      logic [W-1:0]   x, y;
      logic           sw;
      sw = (a < b);
      x  = sw ? b : a;
      y  = sw ? a : b;
      e.res = '0; e.hi = '0; e.sw = 1'b0; e.dz = 1'b0; e.lat = 1;
      case (c)
         3'b000: begin
            s = {1'b0, a} + {1'b0, b};
            e.res = s[W-1:0];
            e.hi  = {{(W-1){1'b0}}, s[W]};
         end
         3'b001: begin
            e.res = x - y;
            e.sw  = sw;
         end
         3'b010: begin
            p = (2*W)'(a) * (2*W)'(b);
            e.res = p[W-1:0];
            e.hi  = p[2*W-1:W];
            e.lat = W;
         end
         3'b011: begin
            e.sw = sw;
            if (y == '0) begin
               e.res = '1; e.hi = x; e.dz = 1'b1;
            end else begin
               e.res = x / y; e.hi = x % y; e.lat = W;
            end
         end
         default: ;
      endcase
      sb.push_back(e);
      inputA = a; inputB = b; code = c; start = 1'b1;
   endtask

   // Waits (bounded) for done; latency counted in edges after the start edge.
   task automatic collect(input bit noise, output exp_t e);
      e = sb.pop_front();
      o_lat = -1;
      for (int n = 0; n <= 4 * W; n++) begin
         @(negedge clk);
         if (n == 0) start = 1'b0;
         if (done === 1'b1) begin
            o_lat = n;
            break;
         end
         if (noise) begin
            start  = 1'($urandom_range(0, 1));
            inputA = W'($urandom);
            inputB = W'($urandom);
            code   = 3'($urandom);
         end
      end
      start = 1'b0;
      o_res = result; o_hi = result_hi; o_sw = swap; o_dz = div_zero;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; inputA = 8'd3; inputB = 8'd4; code = 3'b000;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, result, result_hi, swap, div_zero} !== '0) begin
         errors++;
         $display("FAIL reset_outputs busy=%b done=%b res=%h hi=%h sw=%b dz=%b want all 0",
                  busy, done, result, result_hi, swap, div_zero);
      end
      start = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle busy=%b want 0", busy);
      end
   endtask

   task automatic test_add();
      exp_t e;
      push_op(8'd200, 8'd100, 3'b000);
      collect(1'b0, e);
      checks++;
      if (o_lat !== e.lat) begin
         errors++; $display("FAIL add_latency got %0d want %0d", o_lat, e.lat);
      end
      checks++;
      if ({o_res, o_hi, o_sw, o_dz} !== {e.res, e.hi, e.sw, e.dz} || busy !== 1'b0) begin
         errors++;
         $display("FAIL add_result res=%h hi=%h sw=%b dz=%b busy=%b want res=%h hi=%h sw=%b dz=%b busy=0",
                  o_res, o_hi, o_sw, o_dz, busy, e.res, e.hi, e.sw, e.dz);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result !== e.res) begin
         errors++;
         $display("FAIL add_pulse_hold done=%b res=%h want done=0 res=%h", done, result, e.res);
      end
   endtask

   task automatic test_sub();
      exp_t e;
      logic [W-1:0] av[2] = '{8'd5, 8'd9};
      logic [W-1:0] bv[2] = '{8'd9, 8'd5};
      for (int i = 0; i < 2; i++) begin
         push_op(av[i], bv[i], 3'b001);
         collect(1'b0, e);
         checks++;
         if (o_lat !== e.lat) begin
            errors++; $display("FAIL sub_latency[%0d] got %0d want %0d", i, o_lat, e.lat);
         end
         checks++;
         if ({o_res, o_hi, o_sw, o_dz} !== {e.res, e.hi, e.sw, e.dz}) begin
            errors++;
            $display("FAIL sub_result[%0d] res=%h hi=%h sw=%b dz=%b want res=%h hi=%h sw=%b dz=%b",
                     i, o_res, o_hi, o_sw, o_dz, e.res, e.hi, e.sw, e.dz);
         end
      end
   endtask

   task automatic test_mul();
      exp_t e;
      push_op(8'hFF, 8'hFF, 3'b010);
      collect(1'b1, e);
      checks++;
      if (o_lat !== e.lat) begin
         errors++; $display("FAIL mul_latency got %0d want %0d", o_lat, e.lat);
      end
      checks++;
      if ({o_res, o_hi, o_sw, o_dz} !== {e.res, e.hi, e.sw, e.dz}) begin
         errors++;
         $display("FAIL mul_result res=%h hi=%h sw=%b dz=%b want res=%h hi=%h sw=%b dz=%b",
                  o_res, o_hi, o_sw, o_dz, e.res, e.hi, e.sw, e.dz);
      end
   endtask

   task automatic test_div();
      exp_t e;
      logic [W-1:0] av[2] = '{8'd7, 8'd9};
      logic [W-1:0] bv[2] = '{8'd100, 8'd0};
      for (int i = 0; i < 2; i++) begin
         push_op(av[i], bv[i], 3'b011);
         collect(1'b1, e);
         checks++;
         if (o_lat !== e.lat) begin
            errors++; $display("FAIL div_latency[%0d] got %0d want %0d", i, o_lat, e.lat);
         end
         checks++;
         if ({o_res, o_hi, o_sw, o_dz} !== {e.res, e.hi, e.sw, e.dz}) begin
            errors++;
            $display("FAIL div_result[%0d] res=%h hi=%h sw=%b dz=%b want res=%h hi=%h sw=%b dz=%b",
                     i, o_res, o_hi, o_sw, o_dz, e.res, e.hi, e.sw, e.dz);
         end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      logic [2:0] cv[2] = '{3'b000, 3'b101};
      push_op(8'd250, 8'd10, cv[0]);
      for (int i = 0; i < 2; i++) begin
         collect(1'b0, e);
         if (i == 0) push_op(8'd77, 8'd33, cv[1]);
         checks++;
         if (o_lat !== e.lat) begin
            errors++; $display("FAIL b2b_latency[%0d] got %0d want %0d", i, o_lat, e.lat);
         end
         checks++;
         if ({o_res, o_hi, o_sw, o_dz} !== {e.res, e.hi, e.sw, e.dz}) begin
            errors++;
            $display("FAIL b2b_result[%0d] res=%h hi=%h sw=%b dz=%b want res=%h hi=%h sw=%b dz=%b",
                     i, o_res, o_hi, o_sw, o_dz, e.res, e.hi, e.sw, e.dz);
         end
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int seen;
      inputA = 8'd123; inputB = 8'd45; code = 3'b010; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0; start = 1'b1;
      @(negedge clk);
      rst_n = 1'b1; start = 1'b0;
      checks++;
      if ({busy, done, result, result_hi, swap, div_zero} !== '0) begin
         errors++;
         $display("FAIL midreset_outputs busy=%b done=%b res=%h hi=%h sw=%b dz=%b want all 0",
                  busy, done, result, result_hi, swap, div_zero);
      end
      seen = 0;
      for (int n = 0; n < 2 * W; n++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         errors++; $display("FAIL midreset_quiet busy/done cycles=%0d want 0", seen);
      end
      push_op(8'd100, 8'd7, 3'b011);
      collect(1'b0, e);
      checks++;
      if (o_lat !== e.lat || {o_res, o_hi, o_sw, o_dz} !== {e.res, e.hi, e.sw, e.dz}) begin
         errors++;
         $display("FAIL midreset_div lat=%0d res=%h hi=%h sw=%b dz=%b want lat=%0d res=%h hi=%h sw=%b dz=%b",
                  o_lat, o_res, o_hi, o_sw, o_dz, e.lat, e.res, e.hi, e.sw, e.dz);
      end
   endtask

   task automatic test_random();
      exp_t e;
      logic [W-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = W'($urandom);
         b = (i % 6 == 5) ? '0 : W'($urandom);
         push_op(a, b, 3'($urandom_range(0, 7)));
         collect(i[0], e);
         checks++;
         if (o_lat !== e.lat || {o_res, o_hi, o_sw, o_dz} !== {e.res, e.hi, e.sw, e.dz}) begin
            errors++;
            $display("FAIL random[%0d] a=%h b=%h lat=%0d res=%h hi=%h sw=%b dz=%b want lat=%0d res=%h hi=%h sw=%b dz=%b",
                     i, a, b, o_lat, o_res, o_hi, o_sw, o_dz, e.lat, e.res, e.hi, e.sw, e.dz);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; inputA = '0; inputB = '0; code = '0;
      test_reset();
      test_add();
      test_sub();
      test_mul();
      test_div();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
